// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the byte FIFO and serialises each one as
// start bit, 8 data bits LSB-first, optional parity bit and 1 or 2 stop bits.
// Back-to-back frames are sent without an idle cycle between them.
module uart_tx #(
    parameter int CLKS_PER_BIT = 174,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       enable_i,
    input  logic       have_next_i,
    input  logic [7:0] data_i,
    output logic       next_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int             CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     LAST_STOP  = 3'(STOP_BITS - 1);
    localparam bit             USE_PARITY = (PARITY_EN != 0);
    localparam logic           ODD_BIT    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_reg_n;
    logic          parity_bit;
    logic          parity_bit_n;
    logic          tx_n;
    logic          next_n;
    logic          launch;
    logic          bit_end;
    logic          frame_end;
    logic          do_launch;

    assign launch    = enable_i & have_next_i;
    assign bit_end   = (baud_cnt == CNT_LAST);
    assign frame_end = (state == STOP) && bit_end && (bit_idx == LAST_STOP);
    assign do_launch = launch && ((state == IDLE) || frame_end);

    // Next-state and next-output logic; outputs are registered, so tx_n is the
    // line level for the cycle after the coming edge.
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_cnt;
        bit_idx_n    = bit_idx;
        shift_reg_n  = shift_reg;
        parity_bit_n = parity_bit;
        tx_n         = tx_o;
        next_n       = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                bit_idx_n  = '0;
                tx_n       = 1'b1;
            end

            START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                    tx_n       = shift_reg[0];
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
                        if (USE_PARITY) begin
                            state_n = PARITY;
                            tx_n    = parity_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_idx_n   = bit_idx + 3'd1;
                        shift_reg_n = {1'b0, shift_reg[7:1]};
                        tx_n        = shift_reg[1];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

            PARITY: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = STOP;
                    tx_n       = 1'b1;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == LAST_STOP) begin
                        bit_idx_n = '0;
                        state_n   = IDLE;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_n    = IDLE;
                baud_cnt_n = '0;
                bit_idx_n  = '0;
                tx_n       = 1'b1;
            end
        endcase

        if (do_launch) begin
            shift_reg_n  = data_i;
            parity_bit_n = (^data_i) ^ ODD_BIT;
            next_n       = 1'b1;
            state_n      = START;
            baud_cnt_n   = '0;
            bit_idx_n    = '0;
            tx_n         = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_o       <= 1'b1;
            next_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_idx    <= bit_idx_n;
            shift_reg  <= shift_reg_n;
            parity_bit <= parity_bit_n;
            tx_o       <= tx_n;
            next_o     <= next_n;
            busy_o     <= (state_n != IDLE);
        end
    end

endmodule
